// File: rtl/pcie_bram_fifo_s6.sv
// Valid/ready FIFO built around an external 36-bit BRAM wrapper, hiding its write and
// read latencies behind a small prefetch buffer so the consumer sees one word per clock.
module pcie_bram_fifo_s6 #(
   parameter int DEPTH_LOG2    = 11,
   parameter int WRITE_LATENCY = 1,
   parameter int READ_LATENCY  = 2,
   parameter int BUF_DEPTH     = READ_LATENCY + 2
) (
   input  logic                  user_clk_i,
   input  logic                  reset_n_i,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [35:0]           s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [35:0]           m_data,
   output logic                  wen,
   output logic [11:0]           waddr,
   output logic [35:0]           wdata,
   output logic                  ren,
   output logic                  rce,
   output logic [11:0]           raddr,
   input  logic [35:0]           rdata,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int BIW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int BCW = $clog2(BUF_DEPTH + 1);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2:0]   FULL    = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

   logic [DEPTH_LOG2-1:0] wptr, rptr;
   logic [DEPTH_LOG2:0]   ram_used, ram_used_next, rd_avail;
   logic [READ_LATENCY-1:0] inflight;
   logic [35:0]           buf_mem [BUF_DEPTH];
   logic [BIW-1:0]        buf_head, buf_tail;
   logic [BCW-1:0]        buf_count;
   logic [4:0]            occ;
   logic                  commit, capture, pop;

   function automatic logic [BIW-1:0] bump(input logic [BIW-1:0] idx);
      return (idx == BIW'(BUF_DEPTH - 1)) ? '0 : idx + BIW'(1);
   endfunction

   assign rce     = 1'b1;
   assign wen     = s_valid & s_ready;
   assign wdata   = s_data;
   assign waddr   = 12'(wptr);
   assign raddr   = 12'(rptr);
   assign level   = ram_used;
   assign m_valid = (buf_count != '0);
   assign m_data  = buf_mem[buf_head];
   assign pop     = m_valid & m_ready;
   assign capture = inflight[READ_LATENCY-1];

   // A write becomes readable once the wrapper has committed it; with zero write
   // latency the accepted word is visible to the read side right away.
   generate
      if (WRITE_LATENCY == 0) begin : g_wl0
         assign commit = wen;
      end else begin : g_wl
         logic [WRITE_LATENCY-1:0] wr_dly;
         always_ff @(posedge user_clk_i or negedge reset_n_i) begin
            if (!reset_n_i) wr_dly <= '0;
            else            wr_dly <= WRITE_LATENCY'({wr_dly, wen});
         end
         assign commit = wr_dly[WRITE_LATENCY-1];
      end
   endgenerate

   // Only issue a read when the buffer is guaranteed a free slot for its data.
   always_comb begin
      occ = 5'(buf_count);
      for (int i = 0; i < READ_LATENCY; i++) occ = occ + 5'(inflight[i]);
      ren = (rd_avail != '0) && (occ < 5'(BUF_DEPTH));
   end

   always_comb begin
      ram_used_next = ram_used;
      if (wen && !ren)      ram_used_next = ram_used + CNT_ONE;
      else if (!wen && ren) ram_used_next = ram_used - CNT_ONE;
   end

   always_ff @(posedge user_clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr     <= '0;
         rptr     <= '0;
         ram_used <= '0;
         rd_avail <= '0;
         s_ready  <= 1'b0;
         inflight <= '0;
      end else begin
         ram_used <= ram_used_next;
         s_ready  <= (ram_used_next != FULL);
         inflight <= READ_LATENCY'({inflight, ren});
         if (wen) wptr <= wptr + PTR_ONE;
         if (ren) rptr <= rptr + PTR_ONE;
         case ({commit, ren})
            2'b10:   rd_avail <= rd_avail + CNT_ONE;
            2'b01:   rd_avail <= rd_avail - CNT_ONE;
            default: rd_avail <= rd_avail;
         endcase
      end
   end

   always_ff @(posedge user_clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         buf_head  <= '0;
         buf_tail  <= '0;
         buf_count <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
      end else begin
         if (capture) begin
            buf_mem[buf_tail] <= rdata;
            buf_tail          <= bump(buf_tail);
         end
         if (pop) buf_head <= bump(buf_head);
         case ({capture, pop})
            2'b10:   buf_count <= buf_count + BCW'(1);
            2'b01:   buf_count <= buf_count - BCW'(1);
            default: buf_count <= buf_count;
         endcase
      end
   end

`ifndef SYNTHESIS
   always @(posedge user_clk_i) begin
      if (reset_n_i) assert (!(capture && !pop && buf_count == BCW'(BUF_DEPTH)));
   end
`endif

endmodule

// File: tb/tb_pcie_bram_fifo_s6.sv
// Scoreboard bench for pcie_bram_fifo_s6 with a behavioural BRAM wrapper
// (write latency 1, read latency 2: address register plus output register).
module tb_pcie_bram_fifo_s6;

   localparam int DEPTH    = 2048;
   localparam int BUF_D    = 4;

   logic        clk, reset_n;
   logic        s_valid, s_ready, m_valid, m_ready;
   logic [35:0] s_data, m_data, wdata, rdata;
   logic        wen, ren, rce;
   logic [11:0] waddr, raddr;
   logic [11:0] level;

   logic [35:0] ram [4096];
   logic        wq_en;
   logic [11:0] wq_addr;
   logic [35:0] wq_data, rd_stage;

   logic [35:0] exp_q [$];
   int vectors, miscompares, accept_cnt, pop_cnt;

   pcie_bram_fifo_s6 dut (
      .user_clk_i(clk), .reset_n_i(reset_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .wen(wen), .waddr(waddr), .wdata(wdata),
      .ren(ren), .rce(rce), .raddr(raddr), .rdata(rdata),
      .level(level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Wrapper model: write committed one edge after sampling, read data two edges after ren.
   always @(posedge clk) begin
      wq_en   <= wen;
      wq_addr <= waddr;
      wq_data <= wdata;
      if (wq_en) ram[wq_addr] <= wq_data;
      if (ren) rd_stage <= ram[raddr];
      rdata <= rd_stage;
   end

   // Monitor: record accepted inputs, compare every delivered output against them.
   initial begin
      logic [35:0] want;
      forever begin
         @(negedge clk);
         if (s_valid && s_ready) begin
            exp_q.push_back(s_data);
            accept_cnt++;
         end
         if (m_valid && m_ready) begin
            pop_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL unexpected_output: got %h, want no word", m_data);
            end else begin
               want = exp_q.pop_front();
               if (m_data !== want) begin
                  miscompares++;
                  $display("[TB] FAIL data_order: got %h, want %h", m_data, want);
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Offer one word and return just after the edge that accepted it; s_valid stays high.
   task automatic applyStimulus(input logic [35:0] d);
      int t = 0;
      s_valid = 1'b1;
      s_data  = d;
      while (!s_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 100) begin
         checkOutput("write_timeout", 64'(t), 64'(0));
         s_valid = 1'b0;
      end else begin
         @(posedge clk); #1;
      end
   endtask

   task automatic waitDrain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 5000) begin
         @(posedge clk); #1;
         t++;
      end
      checkOutput(name, 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      int stalls, gaps, t, base, cyc, target, bad;
      vectors = 0; miscompares = 0; accept_cnt = 0; pop_cnt = 0;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b0; reset_n = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_s_ready", 64'(s_ready), 64'(0));
      checkOutput("rst_m_valid", 64'(m_valid), 64'(0));
      checkOutput("rst_m_data", 64'(m_data), 64'(0));
      checkOutput("rst_ren", 64'(ren), 64'(0));
      checkOutput("rst_wen", 64'(wen), 64'(0));
      checkOutput("rst_level", 64'(level), 64'(0));
      checkOutput("rst_rce", 64'(rce), 64'(1));
      reset_n = 1'b1;
      #1 checkOutput("s_ready_before_edge", 64'(s_ready), 64'(0));
      @(posedge clk); #1;
      checkOutput("s_ready_after_release", 64'(s_ready), 64'(1));

      // Single word latency into an empty FIFO.
      m_ready = 1'b1;
      s_valid = 1'b1;
      s_data  = 36'h123456789;
      @(posedge clk); #1;
      s_valid = 1'b0;
      checkOutput("single_level", 64'(level), 64'(1));
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("single_m_valid_%0d", k), 64'(m_valid), 64'(k == 4));
      end
      checkOutput("single_m_data", 64'(m_data), 64'h123456789);
      @(posedge clk); #1;
      checkOutput("single_level_back", 64'(level), 64'(0));
      checkOutput("single_drained", 64'(m_valid), 64'(0));

      // Back-to-back burst of 100 words with the consumer always ready.
      stalls = 0; gaps = 0;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               if (!s_ready) stalls++;
               applyStimulus(36'(i + 1000));
            end
            s_valid = 1'b0;
         end
         begin
            t = 0;
            while (!m_valid && t < 50) begin
               @(posedge clk); #1;
               t++;
            end
            if (t >= 50) gaps = 999;
            for (int i = 0; i < 100; i++) begin
               if (!m_valid) gaps++;
               @(posedge clk); #1;
            end
         end
      join
      checkOutput("burst_s_ready_stalls", 64'(stalls), 64'(0));
      checkOutput("burst_output_gaps", 64'(gaps), 64'(0));
      checkOutput("burst_drained", 64'(m_valid), 64'(0));

      // Consumer stalled: RAM fills to depth plus the prefetch buffer.
      m_ready = 1'b0;
      base = accept_cnt;
      cyc = 0;
      s_valid = 1'b1;
      s_data = 36'h500000000;
      while (s_ready && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
         s_data = 36'h500000000 + 36'(cyc);
      end
      repeat (3) @(posedge clk);
      #1;
      checkOutput("full_accepted", 64'(accept_cnt - base), 64'(DEPTH + BUF_D));
      checkOutput("full_s_ready", 64'(s_ready), 64'(0));
      checkOutput("full_level", 64'(level), 64'(DEPTH));
      checkOutput("full_m_valid", 64'(m_valid), 64'(1));
      s_valid = 1'b0;
      m_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("full_ren_after_pop", 64'(ren), 64'(1));
      checkOutput("full_s_ready_held", 64'(s_ready), 64'(0));
      @(posedge clk); #1;
      checkOutput("full_s_ready_back", 64'(s_ready), 64'(1));
      waitDrain("full_drain");

      // Random traffic long enough to wrap the pointers many times.
      target = pop_cnt + 20000;
      fork
         begin
            for (int n = 0; n < 20000; n++) begin
               if ($urandom_range(3) == 0) begin
                  s_valid = 1'b0;
                  @(posedge clk); #1;
               end
               applyStimulus({4'($urandom), 32'($urandom)});
            end
            s_valid = 1'b0;
         end
         begin
            cyc = 0;
            while (pop_cnt < target && cyc < 60000) begin
               m_ready = ($urandom_range(3) != 0);
               @(posedge clk); #1;
               cyc++;
            end
            m_ready = 1'b1;
         end
      join
      checkOutput("random_all_delivered", 64'(pop_cnt), 64'(target));

      // Reset while words are stored and reads are in flight.
      m_ready = 1'b0;
      for (int i = 0; i < 10; i++) applyStimulus(36'(36'h0A0000000 + 36'(i)));
      s_valid = 1'b0;
      m_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("pre_reset_busy", 64'(level != 0 || m_valid), 64'(1));
      s_valid = 1'b1;
      s_data = 36'hFFFFFFFFF;
      reset_n = 1'b0;
      #1;
      checkOutput("mid_rst_s_ready", 64'(s_ready), 64'(0));
      checkOutput("mid_rst_m_valid", 64'(m_valid), 64'(0));
      checkOutput("mid_rst_m_data", 64'(m_data), 64'(0));
      checkOutput("mid_rst_ren", 64'(ren), 64'(0));
      checkOutput("mid_rst_wen", 64'(wen), 64'(0));
      checkOutput("mid_rst_waddr", 64'(waddr), 64'(0));
      checkOutput("mid_rst_raddr", 64'(raddr), 64'(0));
      checkOutput("mid_rst_level", 64'(level), 64'(0));
      s_valid = 1'b0;
      exp_q.delete();
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (m_valid || ren) bad++;
      end
      checkOutput("post_reset_quiet", 64'(bad), 64'(0));
      applyStimulus(36'hABCDE1234);
      s_valid = 1'b0;
      waitDrain("post_reset_drain");

      checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
